// File: rtl/byte_striping_tx_pkg.sv
// byte_striping_tx_pkg: shared constants and phase encoding for the two-lane byte striping link
package byte_striping_tx_pkg;
    localparam int DATA_W = 8;
    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;
    typedef enum logic {PH_FIRST = 1'b0, PH_SECOND = 1'b1} phase_t;
endpackage

// File: rtl/stripe_lane_fifo.sv
// stripe_lane_fifo: per-lane FIFO with synchronous write and show-ahead read data
module stripe_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int DATA_W = 8
) (
    input  logic                    clk_2f,
    input  logic                    reset_L,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       dout,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk_2f) begin
        if (push) mem[wr_ptr] <= din;
    end
    assign dout  = mem[rd_ptr];
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/byte_striping_tx.sv
// byte_striping_tx: stripes a byte stream alternately onto two half-rate lanes, emitting whole pairs per frame.
// Define STRIPE_IDLE_FLUSH_EN to let a lone lane 0 byte leave on its own after a fully idle frame.
module byte_striping_tx
    import byte_striping_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_stripe_0,
    output logic [DATA_W-1:0] data_stripe_1,
    output logic              valid_stripe_0,
    output logic              valid_stripe_1,
    output logic              phase_f
);
    phase_t phase, phase_nxt;
    logic ptr, ptr_nxt, accept, boundary, pair, flush;
    logic [1:0] push, pop, empty, full;
    logic [DATA_W-1:0] dout [2];
    logic [$clog2(DEPTH):0] count [2];
    for (genvar i = 0; i < 2; i++) begin : g_lane
        stripe_lane_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
            .clk_2f (clk_2f),
            .reset_L(reset_L),
            .push   (push[i]),
            .pop    (pop[i]),
            .din    (data_in),
            .dout   (dout[i]),
            .empty  (empty[i]),
            .full   (full[i]),
            .count  (count[i])
        );
    end
`ifdef STRIPE_IDLE_FLUSH_EN
    logic last_valid;
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) last_valid <= 1'b0;
        else last_valid <= valid_in;
    end
`endif
    assign ready_in = reset_L && count[ptr] != ($clog2(DEPTH)+1)'(DEPTH);
    assign phase_f  = phase;
    assign push     = {accept && ptr == LANE1 && !full[1], accept && ptr == LANE0 && !full[0]};
    assign pop      = {pair, pair || flush};
    always_comb begin
        phase_nxt = phase == PH_FIRST ? PH_SECOND : PH_FIRST;
        boundary  = phase == PH_SECOND;
        pair      = boundary && !empty[0] && !empty[1];
`ifdef STRIPE_IDLE_FLUSH_EN
        flush     = boundary && !empty[0] && empty[1] && !valid_in && !last_valid;
`else
        flush     = 1'b0;
`endif
        accept    = valid_in && ready_in;
        ptr_nxt   = flush ? LANE0 : accept ? ~ptr : ptr;
    end
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            phase          <= PH_FIRST;
            ptr            <= LANE0;
            data_stripe_0  <= '0;
            data_stripe_1  <= '0;
            valid_stripe_0 <= 1'b0;
            valid_stripe_1 <= 1'b0;
        end else begin
            phase <= phase_nxt;
            ptr   <= ptr_nxt;
            if (boundary) begin
                valid_stripe_0 <= pair || flush;
                valid_stripe_1 <= pair;
                if (pair || flush) data_stripe_0 <= dout[0];
                if (pair) data_stripe_1 <= dout[1];
            end
        end
    end
endmodule

// File: tb/tb_byte_striping_tx.sv
// tb_byte_striping_tx: randomized and directed stimulus checked every cycle against a queue-based lane model
module tb_byte_striping_tx;
    localparam int DEPTH = 2;
    logic       clk_2f = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_in, valid_stripe_0, valid_stripe_1, phase_f;
    logic [7:0] data_stripe_0, data_stripe_1;
    int errors = 0;
    int checks = 0;
    logic [7:0]  q0[$], q1[$];
    logic [17:0] cap[$];
    bit         mptr, mphase, mvprev, mv0, mv1;
    logic [7:0] md0, md1;

    byte_striping_tx #(.DEPTH(DEPTH)) dut (
        .clk_2f        (clk_2f),
        .reset_L       (reset_L),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .ready_in      (ready_in),
        .data_stripe_0 (data_stripe_0),
        .data_stripe_1 (data_stripe_1),
        .valid_stripe_0(valid_stripe_0),
        .valid_stripe_1(valid_stripe_1),
        .phase_f       (phase_f)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit mready();
        return (mptr ? q1.size() : q0.size()) < DEPTH;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        mptr = 0; mphase = 0; mvprev = 0; mv0 = 0; mv1 = 0;
        md0 = 8'h00; md1 = 8'h00;
    endtask

    task automatic chk_outputs();
        chk("valid_stripe_0", valid_stripe_0, mv0);
        chk("valid_stripe_1", valid_stripe_1, mv1);
        chk("data_stripe_0", data_stripe_0, md0);
        chk("data_stripe_1", data_stripe_1, md1);
        chk("phase_f", phase_f, mphase);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        valid_in = 1'b0;
        #1;
        model_reset();
        chk_outputs();
        chk("ready_in_reset", ready_in, 0);
        repeat (4) @(posedge clk_2f);
        #1;
        chk_outputs();
        chk("ready_in_reset", ready_in, 0);
        #1 reset_L = 1'b1;
        #1 chk("phase_f_release", phase_f, 0);
    endtask

    task automatic cycle(input bit v, input logic [7:0] d);
        bit acc, bnd, pr, fl;
        @(negedge clk_2f);
        valid_in = v;
        data_in = d;
        #1;
        chk("ready_in", ready_in, mready());
        acc = v && mready();
        @(posedge clk_2f);
        bnd = mphase;
        pr = bnd && q0.size() > 0 && q1.size() > 0;
        fl = 0;
`ifdef STRIPE_IDLE_FLUSH_EN
        fl = bnd && q0.size() > 0 && q1.size() == 0 && !v && !mvprev;
`endif
        if (bnd) begin
            mv0 = pr || fl;
            mv1 = pr;
        end
        if (pr || fl) md0 = q0.pop_front();
        if (pr) md1 = q1.pop_front();
        if (acc) begin
            if (mptr) q1.push_back(d);
            else q0.push_back(d);
            mptr = ~mptr;
        end
        if (fl) mptr = 0;
        mvprev = v;
        mphase = ~mphase;
        #1;
        chk_outputs();
        if (bnd && (valid_stripe_0 || valid_stripe_1))
            cap.push_back({valid_stripe_0, valid_stripe_1, data_stripe_0, data_stripe_1});
    endtask

    task automatic expect_caps(input int n, input logic [17:0] e0, input logic [17:0] e1,
                               input logic [17:0] e2, input logic [17:0] e3);
        logic [17:0] lit [4];
        lit = '{e0, e1, e2, e3};
        chk("pair_count", cap.size(), n);
        for (int i = 0; i < n && i < cap.size(); i++) chk("pair_value", cap[i], lit[i]);
        cap.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00);
    endtask

    initial begin
        model_reset();
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1, 8'(i));
        idle(4);
        expect_caps(4, {2'b11, 8'h01, 8'h02}, {2'b11, 8'h03, 8'h04},
                       {2'b11, 8'h05, 8'h06}, {2'b11, 8'h07, 8'h08});
        cycle(1, 8'hA0); idle(2);
        cycle(1, 8'hA1); cycle(1, 8'hA2); idle(1);
        cycle(1, 8'hA3); idle(4);
        expect_caps(2, {2'b11, 8'hA0, 8'hA1}, {2'b11, 8'hA2, 8'hA3}, '0, '0);
        cycle(1, 8'h11); cycle(1, 8'h22); cycle(1, 8'h33);
        idle(10);
`ifdef STRIPE_IDLE_FLUSH_EN
        expect_caps(2, {2'b11, 8'h11, 8'h22}, {2'b10, 8'h33, 8'h22}, '0, '0);
`else
        expect_caps(1, {2'b11, 8'h11, 8'h22}, '0, '0, '0);
`endif
        cycle(1, 8'h44);
        idle(6);
`ifdef STRIPE_IDLE_FLUSH_EN
        expect_caps(1, {2'b10, 8'h44, 8'h22}, '0, '0, '0);
`else
        expect_caps(1, {2'b11, 8'h33, 8'h44}, '0, '0, '0);
`endif
        do_reset();
        cycle(1, 8'h12); cycle(1, 8'h34); cycle(1, 8'h55); idle(1);
        expect_caps(1, {2'b11, 8'h12, 8'h34}, '0, '0, '0);
        do_reset();
        cycle(1, 8'h66); cycle(1, 8'h77); idle(4);
        expect_caps(1, {2'b11, 8'h66, 8'h77}, '0, '0, '0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) idle($urandom_range(2, 6));
            cycle($urandom_range(0, 9) < 7, 8'($urandom));
        end
        idle(6);
        cap.delete();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
